// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and width helpers for the Fifo write-port arbiter.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

    // Grant index width never collapses to zero bits.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer request bus plus Fifo write-side signals seen by the arbiter.
interface fifo_write_arbiter_if
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GID_W = id_width(DEF_N_REQ)
);
    logic [N_REQ-1:0]       REQ_VALID;
    logic [N_REQ*WIDTH-1:0] REQ_DATA;
    logic [N_REQ-1:0]       REQ_READY;
    logic [WIDTH-1:0]       FIFO_DIN;
    logic                   FIFO_WE;
    logic                   FIFO_FULL;
    logic [GID_W-1:0]       GRANT_ID;
    logic                   BUSY;

    modport master (
        output REQ_VALID, REQ_DATA, FIFO_FULL,
        input  REQ_READY, FIFO_DIN, FIFO_WE, GRANT_ID, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, FIFO_FULL,
        output REQ_READY, FIFO_DIN, FIFO_WE, GRANT_ID, BUSY
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first valid requester after ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        cand    = '0;
        // ptr itself is scanned last, so the previous owner has lowest priority.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
            if (!found_o && valid_i[cand]) begin
                found_o = 1'b1;
                index_o = cand;
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one Fifo write port among N_REQ producers.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 CLK,
    input  logic                 RESET,
    fifo_write_arbiter_if.slave  bus
);
    localparam int unsigned GID_W = id_width(N_REQ);
    localparam int unsigned CNT_W = cnt_width(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [GID_W-1:0] ptr_q, ptr_d;
    logic [GID_W-1:0] gid_q, gid_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic             pick_found;
    logic [GID_W-1:0] pick_idx;
    logic             g_valid;
    logic [WIDTH-1:0] g_data;
    logic             xfer;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (GID_W)
    ) u_picker (
        .valid_i (bus.REQ_VALID),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    assign g_valid = bus.REQ_VALID[gid_q];
    assign g_data  = bus.REQ_DATA[32'(gid_q)*WIDTH +: WIDTH];
    assign xfer    = (state_q == ST_GRANT) && g_valid && !bus.FIFO_FULL;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= GID_W'(N_REQ - 1);
            gid_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    gid_d   = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_GRANT: begin
                // Full stalls the grant; only a dropped VALID or a completed burst releases it.
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = gid_q;
                    end
                end else if (!g_valid) begin
                    state_d = ST_IDLE;
                    ptr_d   = gid_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.REQ_READY = '0;
        bus.FIFO_WE   = 1'b0;
        bus.FIFO_DIN  = '0;
        bus.BUSY      = (state_q == ST_GRANT);
        bus.GRANT_ID  = gid_q;
        if (state_q == ST_GRANT) begin
            bus.REQ_READY[gid_q] = !bus.FIFO_FULL;
            bus.FIFO_WE          = xfer;
            if (xfer) begin
                bus.FIFO_DIN = g_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized scoreboard bench for fifo_write_arbiter against a transaction-level model.
module tb_fifo_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic CLK = 1'b0;
    logic RESET;

    fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W), .GID_W(2)) bus();

    fifo_write_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         id;
        logic [7:0] data;
    } beat_t;

    beat_t sb[$];
    int checks   = 0;
    int failures = 0;
    int n_pushed  = 0;
    int n_written = 0;

    // Model: owner<0 means a bubble cycle, last is the previous owner for rotation.
    int owner, last, gid, beats;
    int seq[N];
    logic       chk_en = 1'b0;
    logic       exp_busy;
    logic [1:0] exp_gid;
    logic [3:0] exp_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mkdata(input int i, input int s);
        return 8'((i << 6) | (s & 63));
    endfunction

    task automatic model_reset();
        owner = -1;
        last  = N - 1;
        gid   = 0;
        beats = 0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic f);
        exp_busy  = (owner >= 0);
        exp_gid   = 2'(gid);
        exp_ready = (owner >= 0 && !f) ? 4'(1 << owner) : 4'd0;
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (v[c]) begin
                    owner = c;
                    gid   = c;
                    beats = 0;
                    break;
                end
            end
        end else if (v[owner] && !f) begin
            sb.push_back('{owner, mkdata(owner, seq[owner])});
            n_pushed++;
            seq[owner]++;
            beats++;
            if (beats == MB) begin
                last  = owner;
                owner = -1;
            end
        end else if (!v[owner]) begin
            last  = owner;
            owner = -1;
        end
    endtask

    // Called just after a rising edge: apply this cycle's inputs and predict.
    task automatic drive_cycle(input logic [3:0] v, input logic f);
        for (int i = 0; i < N; i++) bus.REQ_DATA[i*W +: W] = mkdata(i, seq[i]);
        bus.REQ_VALID = v;
        bus.FIFO_FULL = f;
        model_step(v, f);
        chk_en = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        logic [3:0] v;
        logic       f;
        v = bus.REQ_VALID;
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLK); #1;
            for (int i = 0; i < N; i++)
                v[i] = v[i] ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
            f = ($urandom_range(3) == 0);
            drive_cycle(v, f);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en && !RESET) begin
            check("busy", 32'(bus.BUSY), 32'(exp_busy));
            check("grant_id", 32'(bus.GRANT_ID), 32'(exp_gid));
            check("ready", 32'(bus.REQ_READY), 32'(exp_ready));
            if (bus.FIFO_WE) begin
                n_written++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=none at %0t", bus.FIFO_DIN, $time);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("din", 32'(bus.FIFO_DIN), 32'(e.data));
                    check("write_id", 32'(bus.GRANT_ID), 32'(e.id));
                end
            end
        end
    end

    initial begin
        int guard;
        RESET         = 1'b0;
        bus.REQ_VALID = '0;
        bus.REQ_DATA  = '0;
        bus.FIFO_FULL = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        model_reset();

        #1 RESET = 1'b1;
        #1;
        check("rst_we", 32'(bus.FIFO_WE), 32'd0);
        check("rst_ready", 32'(bus.REQ_READY), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_gid", 32'(bus.GRANT_ID), 32'd0);
        check("rst_din", 32'(bus.FIFO_DIN), 32'd0);

        bus.REQ_VALID = 4'b1111;
        repeat (5) @(posedge CLK);
        #1;
        check("rst_hold_we", 32'(bus.FIFO_WE), 32'd0);
        check("rst_hold_ready", 32'(bus.REQ_READY), 32'd0);
        check("rst_hold_busy", 32'(bus.BUSY), 32'd0);
        bus.REQ_VALID = '0;
        RESET = 1'b0;
        drive_cycle(4'b0000, 1'b0);

        // Lone producer 1: bursts of MB with a single bubble between re-grants.
        repeat (12) begin @(posedge CLK); #1; drive_cycle(4'b0010, 1'b0); end
        repeat (2)  begin @(posedge CLK); #1; drive_cycle(4'b0000, 1'b0); end
        // Everyone valid: strict rotation.
        repeat (30) begin @(posedge CLK); #1; drive_cycle(4'b1111, 1'b0); end
        // Sustained backpressure with a grant held.
        repeat (6)  begin @(posedge CLK); #1; drive_cycle(4'b1111, 1'b1); end
        repeat (4)  begin @(posedge CLK); #1; drive_cycle(4'b1111, 1'b0); end

        random_phase(400);

        // Steer into a mid-burst grant of producer 2, then reset asynchronously.
        guard = 0;
        do begin
            @(posedge CLK); #1;
            drive_cycle(4'b1111, 1'b0);
            guard++;
        end while (!(owner == 2 && beats >= 1) && guard < 60);
        check("reach_req2_burst", 32'(guard < 60), 32'd1);
        @(posedge CLK); #1;
        chk_en = 1'b0;
        check("pre_reset_we", 32'(bus.FIFO_WE), 32'd1);
        check("pre_reset_gid", 32'(bus.GRANT_ID), 32'd2);
        RESET = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus.FIFO_WE), 32'd0);
        check("mid_rst_ready", 32'(bus.REQ_READY), 32'd0);
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        model_reset();
        RESET = 1'b0;
        drive_cycle(4'b1111, 1'b0);
        repeat (10) begin @(posedge CLK); #1; drive_cycle(4'b1111, 1'b0); end

        random_phase(400);

        repeat (15) begin @(posedge CLK); #1; drive_cycle(4'b0000, 1'b0); end
        @(posedge CLK); #1;
        chk_en = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("write_count", 32'(n_written), 32'(n_pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
